cordic_vec_core: RTL and testbench
==================================

Name: cordic_vec_core

Overview:
- Iterative CORDIC in vectoring mode. Converts a Cartesian pair (x0,y0) into a phase angle and a magnitude, i.e. atan2 plus |v|.
- It is the inverse-direction companion of the rotation-mode sine/cosine core.
- Its angle encoding matches that core exactly (65536 LSB = 2*pi), so a result can be fed straight back to the sin/cos generator.
- Used after I/Q demodulation for phase/amplitude detection.

Parameters:
- w, 16, data/angle width in bits. Internal datapath is w+2 bits.
- st_w, 4, iteration counter width; must satisfy 2^st_w >= w-1.
- gain_k, 19898, CORDIC gain compensation factor, 1/1.64676 in Q15 (only used with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserts when 0).
- start  in  1  request; sampled only in IDLE.
- x0  in  w  signed X (I) component.
- y0  in  w  signed Y (Q) component.
- angle  out  w  signed phase. 0 = 0 rad, 16384 = pi/2, -16384 = -pi/2, -32768 = +/-pi.
- mag  out  w+1  unsigned magnitude.
- busy  out  1  high from accepted start until finish.
- finish  out  1  one-cycle pulse; angle/mag valid from this cycle on.

Behaviour:
- Reset (reset=0, async): state=IDLE; angle=0, mag=0, busy=0, finish=0; internal x, y, z and i cleared. Reset mid-operation aborts with no finish pulse.

States:
- IDLE: on clock edge with start=1, perform the load below and go to ITER. Otherwise hold; outputs keep their last results.
- Load: busy<=1, i<=0, zero flag <= (x0==0 && y0==0).
- Load, quadrant pre-rotation (operands sign-extended to w+2):
  - x0>=0: x=x0, y=y0, z=0.
  - x0<0 and y0>=0: x=y0, y=-x0, z=+16384.
  - x0<0 and y0<0: x=-y0, y=x0, z=-16384.
- ITER: one micro-rotation per clock, i = 0..w-2 (15 iterations for w=16).
  - y>=0: x<=x+(y>>>i), y<=y-(x>>>i), z<=z+t[i].
  - y<0: x<=x-(y>>>i), y<=y+(x>>>i), z<=z-t[i].
  - Shifts are arithmetic on signed w+2 values. Sign-magnitude negate tricks are not used.
  - z arithmetic is w bits, wrapping modulo 2^w (+pi and -pi both encode as -32768).
  - At i==w-2 go to DONE; otherwise i<=i+1.
- Angle table t[0..14] = 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1.
- DONE (one cycle): register the outputs, pulse finish=1, set busy<=0, return to IDLE.
  - angle<=z.
  - mag<=x, saturated to 2^(w+1)-1 (x is never negative here).
  - Zero input forces angle=0, mag=0.

Timing and edge cases:
- Latency: finish is high in the cycle following the (w)th clock edge after the start-accepting edge, i.e. 16 cycles for w=16.
- Back-to-back: start may be high in the same cycle as finish. It is not accepted until the IDLE cycle after finish.
- start while busy: ignored, not queued.
- Accuracy: angle within +/-4 LSB of round(atan2(y0,x0)*32768/pi), modulo 2^16.
- Boundary cases:
  - x0=-32768, y0=0 must not overflow (internal y = +32768 fits in w+2 bits).
  - Largest input vector (-32768,-32768) with gain 1.647 stays below 2^17, so it fits in w+2 signed bits.

Optional Feature:
- Macro: CORDIC_VEC_GAIN_COMP_EN.
- Defined: in DONE, mag <= (x*gain_k)>>>15, rounded by adding 2^14 before the shift. Latency unchanged (multiply is combinational into the DONE register). mag approximately equals sqrt(x0^2+y0^2), within +/-3 LSB, and fits in w+1 bits.
- Undefined: no multiplier; mag = raw x, approximately 1.64676*|v| (saturated as above).

Test Plan:
- Reset held low for 3 cycles then released, no start -> angle=0, mag=0, busy=0, finish=0. Reset=0 pulsed at iteration 7 -> outputs return to 0, no finish, next start completes normally.
- x0=16384, y0=0, start for 1 cycle -> finish exactly 16 cycles later; angle in [-4,4]; mag in 16381..16387 (COMP_EN) or 26977..26983 (raw).
- x0=0, y0=16384 -> angle 16384+/-4. x0=10000, y0=-10000 -> angle -8192+/-4; mag 14142+/-3 (COMP_EN).
- x0=-16384, y0=0 -> angle in 32764..32767 or -32768..-32764. x0=-32768, y0=-1 -> angle near -32768, no overflow; mag 32768+/-3 (COMP_EN).
- x0=0, y0=0 -> angle=0, mag=0, finish pulses once.
- start held high continuously with changing inputs -> one result per 17 cycles. start pulses during busy are ignored. Each result matches the inputs sampled at its own accept edge.

Source files
------------

// File: rtl/cordic_vec_core.sv
// cordic_vec_core: iterative vectoring-mode CORDIC that turns (x0, y0) into
// a phase angle and a magnitude. The angle encoding matches the rotation-mode
// sin/cos core: 65536 LSB = 2*pi, so -32768 stands for +/-pi.
//
// Optional feature macro: CORDIC_VEC_GAIN_COMP_EN
//   defined   -> mag = round(x * gain_k / 2^15), approximately |v|
//   undefined -> mag = raw x, approximately 1.64676 * |v|
//
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   asynchronous active-low reset
//   i_start   request, sampled only in IDLE
//   i_x0      signed X (I) component, w bits
//   i_y0      signed Y (Q) component, w bits
//   o_angle   signed phase, w bits
//   o_mag     unsigned magnitude, w+1 bits
//   o_busy    high from accepted start until finish
//   o_finish  one-cycle pulse; angle/mag valid from this cycle on
//
// state  | meaning
// S_IDLE | waiting for i_start; outputs hold the last result
// S_ITER | one micro-rotation per clock, i = 0 .. w-2
// S_DONE | register angle/mag, pulse finish, return to idle
module cordic_vec_core #(
  parameter int w      = 16,
  parameter int st_w   = 4,
  parameter int gain_k = 19898
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [w-1:0] i_x0,
  input  logic [w-1:0] i_y0,
  output logic [w-1:0] o_angle,
  output logic [w:0]   o_mag,
  output logic         o_busy,
  output logic         o_finish
);

  localparam int DW = w + 2;
  localparam logic [st_w-1:0] LAST_I = st_w'(w - 2);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t                r_state, w_next_state;
  logic signed [DW-1:0]  r_x, r_y;
  logic        [w-1:0]   r_z;
  logic        [st_w-1:0] r_i;
  logic                  r_zero;
  logic        [w-1:0]   r_angle;
  logic        [w:0]     r_mag;
  logic                  r_busy, r_finish;

  logic signed [DW-1:0]  w_x0e, w_y0e, w_xs, w_ys;
  logic        [w-1:0]   w_t;
  logic        [w:0]     w_mag_sat;

  function automatic logic [w-1:0] atan_lut(input logic [st_w-1:0] idx);
    logic [15:0] v;
    case (idx)
      4'd0:    v = 16'd8192;
      4'd1:    v = 16'd4836;
      4'd2:    v = 16'd2555;
      4'd3:    v = 16'd1297;
      4'd4:    v = 16'd651;
      4'd5:    v = 16'd326;
      4'd6:    v = 16'd163;
      4'd7:    v = 16'd81;
      4'd8:    v = 16'd41;
      4'd9:    v = 16'd20;
      4'd10:   v = 16'd10;
      4'd11:   v = 16'd5;
      4'd12:   v = 16'd3;
      4'd13:   v = 16'd1;
      4'd14:   v = 16'd1;
      default: v = 16'd0;
    endcase
    return w'(v);
  endfunction

  assign w_x0e = {{2{i_x0[w-1]}}, i_x0};
  assign w_y0e = {{2{i_y0[w-1]}}, i_y0};
  assign w_xs  = r_x >>> r_i;
  assign w_ys  = r_y >>> r_i;
  assign w_t   = atan_lut(r_i);

`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int PW = DW + 17;
  localparam logic signed [16:0] K = 17'(gain_k);
  logic signed [PW-1:0] w_prod, w_mag_src;
  // Round to nearest by adding half an LSB of the Q15 result before shifting.
  assign w_prod    = PW'(r_x) * PW'(K);
  assign w_mag_src = (w_prod + PW'(1 << 14)) >>> 15;
`else
  localparam int PW = DW;
  logic signed [PW-1:0] w_mag_src;
  assign w_mag_src = r_x;
`endif

  assign w_mag_sat = (|w_mag_src[PW-1:w+1]) ? '1 : w_mag_src[w:0];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_ITER;
      S_ITER:  if (r_i == LAST_I) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_i      <= '0;
      r_zero   <= 1'b0;
      r_angle  <= '0;
      r_mag    <= '0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            r_i    <= '0;
            r_zero <= (i_x0 == '0) && (i_y0 == '0);
            // Pre-rotate left-half-plane inputs by -/+pi/2 so the
            // micro-rotations only ever need to cover +/-pi/2.
            if (!i_x0[w-1]) begin
              r_x <= w_x0e;
              r_y <= w_y0e;
              r_z <= '0;
            end else if (!i_y0[w-1]) begin
              r_x <= w_y0e;
              r_y <= -w_x0e;
              r_z <= w'(16384);
            end else begin
              r_x <= -w_y0e;
              r_y <= w_x0e;
              r_z <= w'(-16384);
            end
          end
        end
        S_ITER: begin
          if (!r_y[DW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_t;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_t;
          end
          if (r_i != LAST_I) r_i <= r_i + 1'b1;
        end
        S_DONE: begin
          r_angle  <= r_zero ? '0 : r_z;
          r_mag    <= r_zero ? '0 : w_mag_sat;
          r_finish <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_angle  = r_angle;
  assign o_mag    = r_mag;
  assign o_busy   = r_busy;
  assign o_finish = r_finish;

endmodule

// File: tb/tb_cordic_vec_core.sv
module tb_cordic_vec_core;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] x0 = '0;
  logic signed [15:0] y0 = '0;
  logic        [15:0] angle;
  logic        [16:0] mag;
  logic               busy, finish;

  always #5 clk = ~clk;

  cordic_vec_core dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_start (start),
    .i_x0    (x0),
    .i_y0    (y0),
    .o_angle (angle),
    .o_mag   (mag),
    .o_busy  (busy),
    .o_finish(finish)
  );

  typedef struct {int x; int y;} vec_t;
  vec_t sb[$];
  vec_t v_cur;

  int  n_vec = 0;
  int  n_bad = 0;
  int  m_cnt = -1;
  bit  m_fin = 1'b0;
  bit  chk_en = 1'b0;
  bit  stream_on = 1'b0;
  int  cyc = 0;
  int  last_fin = -1;

  task automatic chk(input string tag, input int got, input int exp,
                     input int tol, input bit wrap);
    int d;
    n_vec++;
    d = got - exp;
    if (wrap) d = (((d % 65536) + 65536 + 32768) % 65536) - 32768;
    if (d > tol || d < -tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic check_result(input vec_t v);
    real a, m;
    int  ea, em, tol_m;
    if (v.x == 0 && v.y == 0) begin
      chk("angle_zero", int'($signed(angle)), 0, 0, 1'b0);
      chk("mag_zero", int'(mag), 0, 0, 1'b0);
    end else begin
      a  = $atan2(real'(v.y), real'(v.x)) * 32768.0 / 3.14159265358979;
      ea = $rtoi($floor(a + 0.5));
      m  = $sqrt(real'(v.x) * real'(v.x) + real'(v.y) * real'(v.y));
`ifdef CORDIC_VEC_GAIN_COMP_EN
      em    = $rtoi($floor(m + 0.5));
      tol_m = 3;
`else
      em    = $rtoi($floor(m * 1.646760258 + 0.5));
      tol_m = 8;
`endif
      chk("angle", int'($signed(angle)), ea, 4, 1'b1);
      chk("mag", int'(mag), em, tol_m, 1'b0);
    end
  endtask

  // Reference timing model: accept in idle, finish 16 edges later.
  always @(posedge clk) begin
    cyc++;
    m_fin = 1'b0;
    if (!rst_n) begin
      m_cnt = -1;
      sb.delete();
    end else if (m_cnt < 0) begin
      if (start) begin
        sb.push_back('{int'(x0), int'(y0)});
        m_cnt = 0;
      end
    end else if (m_cnt == 15) begin
      m_cnt = -1;
      m_fin = 1'b1;
    end else begin
      m_cnt++;
    end
  end

  always @(posedge clk) begin
    #3;
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_cnt >= 0), 0, 1'b0);
      chk("finish", int'(finish), int'(m_fin), 0, 1'b0);
      if (m_fin) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 0, 1, 0, 1'b0);
        end else begin
          v_cur = sb.pop_front();
          check_result(v_cur);
        end
        if (stream_on && last_fin >= 0) chk("period", cyc - last_fin, 17, 0, 1'b0);
        last_fin = cyc;
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (m_cnt < 0 && sb.size() == 0) return;
    end
    chk("idle_timeout", 1, 0, 0, 1'b0);
  endtask

  task automatic apply(input int x, input int y);
    @(negedge clk);
    x0 = 16'(x);
    y0 = 16'(y);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  task automatic rand_vec(output int x, output int y);
    do begin
      x = int'($urandom_range(0, 65535)) - 32768;
      y = int'($urandom_range(0, 65535)) - 32768;
    end while ((x < 8192 && x > -8192) && (y < 8192 && y > -8192));
  endtask

  initial begin
    int rx, ry;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_angle", int'(angle), 0, 0, 1'b0);
    chk("rst_mag", int'(mag), 0, 0, 1'b0);

    apply(16384, 0);
    apply(0, 16384);
    apply(10000, -10000);
    apply(-16384, 0);
    apply(-32768, -1);
    apply(-32768, 0);
    apply(-32768, -32768);
    apply(32767, 32767);
    apply(0, 0);
    apply(-12000, 20000);

    // Reset during iteration 7 aborts with outputs cleared and no finish.
    @(negedge clk);
    x0 = 16'sd10000; y0 = -16'sd10000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_angle", int'(angle), 0, 0, 1'b0);
    chk("abort_mag", int'(mag), 0, 0, 1'b0);
    chk("abort_busy", int'(busy), 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(20000, 5000);

    // Starts while busy are ignored.
    @(negedge clk);
    x0 = 16'sd9000; y0 = 16'sd15000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    x0 = -16'sd20000; y0 = 16'sd3000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    x0 = 16'sd1234; y0 = -16'sd30000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    for (int k = 0; k < 6; k++) begin
      rand_vec(rx, ry);
      apply(rx, ry);
    end

    // Continuous start with inputs changing every cycle.
    stream_on = 1'b1;
    last_fin  = -1;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      rand_vec(rx, ry);
      x0 = 16'(rx);
      y0 = 16'(ry);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    stream_on = 1'b0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
